// File: rtl/res_mem_ctrl_pkg.sv
// Shared definitions for the FPU result collector: sizes, command codes and FSM states.
// Sizes are used as parameter defaults by the controller, the RAM and the bus interface.
package res_mem_pkg;

  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] CMD_COLLECT = 3'b100;
  localparam logic [2:0] CMD_DRAIN   = 3'b010;
  localparam logic [2:0] CMD_ABORT   = 3'b001;
  localparam logic [2:0] CMD_NOP     = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_OUT   = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

  // A zero length means a full buffer.
  function automatic logic [CW-1:0] length_to_target(input logic [AW-1:0] len);
    return (len == '0) ? CW'(DEPTH) : CW'(len);
  endfunction

endpackage

// File: rtl/res_mem_ctrl_if.sv
// Result-RAM port plus the drained-word stream (valid/ready) of the collector.
// master = controller side, slave = RAM / downstream side.
interface res_mem_ctrl_if #(
  parameter int AW = $clog2(res_mem_pkg::DEPTH),
  parameter int DW = res_mem_pkg::DW
);

  logic [AW-1:0] rc_mem_addr;
  logic          rc_mem_we;
  logic [DW-1:0] rc_mem_wdata;
  logic [DW-1:0] rc_mem_rdata;
  logic [DW-1:0] rc_data_out;
  logic          rc_out_valid;
  logic          rc_out_ready;

  modport master (
    output rc_mem_addr,
    output rc_mem_we,
    output rc_mem_wdata,
    output rc_data_out,
    output rc_out_valid,
    input  rc_mem_rdata,
    input  rc_out_ready
  );

  modport slave (
    input  rc_mem_addr,
    input  rc_mem_we,
    input  rc_mem_wdata,
    input  rc_data_out,
    input  rc_out_valid,
    output rc_mem_rdata,
    output rc_out_ready
  );

endinterface

// File: rtl/res_mem_ctrl_ram.sv
// Result RAM: one write port, registered read (data appears the cycle after the address).
// Instantiated beside the controller; contents are deliberately not reset.
module res_ram
  import res_mem_pkg::*;
#(
  parameter int DEPTH = res_mem_pkg::DEPTH,
  parameter int DW    = res_mem_pkg::DW
) (
  input  logic                     mc_clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read-before-write on a same-address collision.
  always_ff @(posedge mc_clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/res_mem_ctrl.sv
// Collects FPU results into an external RAM, then drains them as a valid/ready stream.
// Status outputs decode from the state register, so reset clears them asynchronously.
module res_mem_ctrl #(
  parameter int DEPTH = res_mem_pkg::DEPTH,
  parameter int DW    = res_mem_pkg::DW
) (
  input  logic                       mc_clk,
  input  logic                       mc_reset,
  input  logic [2:0]                 rc_cmd,
  input  logic [$clog2(DEPTH)-1:0]   rc_length,
  input  logic [DW-1:0]              fpu_result,
  input  logic                       fpu_valid,
  res_mem_ctrl_if.master             bus,
  output logic                       rc_done,
  output logic [$clog2(DEPTH+1)-1:0] rc_count,
  output logic                       rc_busy
);
  import res_mem_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] target_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [DW-1:0] data_reg;
  logic          first_reg;

  logic          abort_cmd;
  logic          wr_fire;
  logic          last_write;
  logic          last_read;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          out_valid;

  assign abort_cmd  = (rc_cmd == CMD_ABORT);
  assign wr_fire    = (state_reg == ST_COLLECT) && fpu_valid && !abort_cmd;
  assign last_write = ((count_reg + CW'(1)) == target_reg);
  assign last_read  = ((CW'(rd_ptr_reg) + CW'(1)) == count_reg);

  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rc_cmd == CMD_COLLECT) begin
          state_next = ST_COLLECT;
        end else if (rc_cmd == CMD_DRAIN) begin
          state_next = (count_reg == '0) ? ST_FINISH : ST_RD_ISSUE;
        end
      end
      ST_COLLECT: begin
        if (abort_cmd) begin
          state_next = ST_IDLE;
        end else if (fpu_valid && last_write) begin
          state_next = ST_FINISH;
        end
      end
      ST_RD_ISSUE: begin
        state_next = abort_cmd ? ST_IDLE : ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (abort_cmd) begin
          state_next = ST_IDLE;
        end else if (bus.rc_out_ready) begin
          state_next = last_read ? ST_FINISH : ST_RD_ISSUE;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    out_valid = 1'b0;
    rc_done   = 1'b0;
    rc_busy   = (state_reg != ST_IDLE);
    case (state_reg)
      ST_COLLECT: begin
        if (wr_fire) begin
          mem_we    = 1'b1;
          mem_addr  = wr_ptr_reg;
          mem_wdata = fpu_result;
        end
      end
      ST_RD_ISSUE: begin
        mem_addr = rd_ptr_reg;
      end
      ST_RD_OUT: begin
        out_valid = 1'b1;
      end
      ST_FINISH: begin
        rc_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers. On the first RD_OUT cycle the RAM read port already
  // holds the word, so it is passed straight through and captured for any stall.
  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      count_reg  <= '0;
      target_reg <= CW'(DEPTH);
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      data_reg   <= '0;
      first_reg  <= 1'b0;
    end else begin
      first_reg <= (state_reg == ST_RD_ISSUE) && (state_next == ST_RD_OUT);
      case (state_reg)
        ST_IDLE: begin
          if (rc_cmd == CMD_COLLECT) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            target_reg <= (rc_length == '0) ? CW'(DEPTH) : CW'(rc_length);
          end else if (rc_cmd == CMD_DRAIN) begin
            rd_ptr_reg <= '0;
          end
        end
        ST_COLLECT: begin
          if (wr_fire) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
            count_reg  <= count_reg + CW'(1);
          end
        end
        ST_RD_OUT: begin
          if (first_reg) begin
            data_reg <= bus.rc_mem_rdata;
          end
          if (bus.rc_out_ready && !abort_cmd) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rc_mem_addr  = mem_addr;
  assign bus.rc_mem_we    = mem_we;
  assign bus.rc_mem_wdata = mem_wdata;
  assign bus.rc_out_valid = out_valid;
  assign bus.rc_data_out  = (state_reg == ST_RD_OUT && first_reg) ? bus.rc_mem_rdata : data_reg;
  assign rc_count         = count_reg;

endmodule

// File: tb/tb_res_mem_ctrl.sv
// Directed bench for res_mem_ctrl with the result RAM instantiated alongside it.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_res_mem_ctrl;
  import res_mem_pkg::*;

  logic        mc_clk = 1'b0;
  logic        mc_reset = 1'b1;
  logic [2:0]  rc_cmd = 3'b000;
  logic [5:0]  rc_length = 6'd0;
  logic [31:0] fpu_result = 32'h0;
  logic        fpu_valid = 1'b0;
  logic        rc_done;
  logic [6:0]  rc_count;
  logic        rc_busy;
  int          total = 0;
  int          bad = 0;

  res_mem_ctrl_if bus ();

  res_mem_ctrl dut (
    .mc_clk     (mc_clk),
    .mc_reset   (mc_reset),
    .rc_cmd     (rc_cmd),
    .rc_length  (rc_length),
    .fpu_result (fpu_result),
    .fpu_valid  (fpu_valid),
    .bus        (bus),
    .rc_done    (rc_done),
    .rc_count   (rc_count),
    .rc_busy    (rc_busy)
  );

  res_ram ram (
    .mc_clk (mc_clk),
    .addr   (bus.rc_mem_addr),
    .we     (bus.rc_mem_we),
    .wdata  (bus.rc_mem_wdata),
    .rdata  (bus.rc_mem_rdata)
  );

  always #5 mc_clk = ~mc_clk;

  task automatic tick();
    @(posedge mc_clk);
    #1;
  endtask

  task automatic test_reset();
    mc_reset = 1'b1;
    bus.rc_out_ready = 1'b1;
    tick();
    tick();
    #1;
    total++; if (rc_busy !== 1'b0) $display("FAIL reset_busy: got=%b want=0", rc_busy);
    if (rc_busy !== 1'b0) bad++;
    total++; if (rc_count !== 7'd0 || rc_done !== 1'b0) begin
      bad++; $display("FAIL reset_status: count=%0d done=%b want count=0 done=0", rc_count, rc_done);
    end
    total++; if (bus.rc_out_valid !== 1'b0 || bus.rc_data_out !== 32'h0) begin
      bad++; $display("FAIL reset_out: valid=%b data=%h want valid=0 data=0", bus.rc_out_valid, bus.rc_data_out);
    end
    total++; if (bus.rc_mem_we !== 1'b0 || bus.rc_mem_addr !== 6'd0) begin
      bad++; $display("FAIL reset_mem: we=%b addr=%0d want we=0 addr=0", bus.rc_mem_we, bus.rc_mem_addr);
    end
    mc_reset = 1'b0;
    tick();
    // Drain of an empty buffer finishes straight away.
    rc_cmd = CMD_DRAIN;
    tick();
    rc_cmd = CMD_NOP;
    #1;
    total++; if (rc_done !== 1'b1 || bus.rc_out_valid !== 1'b0) begin
      bad++; $display("FAIL empty_drain: done=%b valid=%b want done=1 valid=0", rc_done, bus.rc_out_valid);
    end
    tick();
    #1;
    total++; if (rc_done !== 1'b0 || rc_busy !== 1'b0) begin
      bad++; $display("FAIL empty_drain_end: done=%b busy=%b want 0 0", rc_done, rc_busy);
    end
  endtask

  task automatic run_drain(input int n, input logic [31:0] base, input int stall_word,
                           input int stall_cycles, input string tag);
    logic [31:0] exp;
    bus.rc_out_ready = 1'b1;
    rc_cmd = CMD_DRAIN;
    tick();
    rc_cmd = CMD_NOP;
    for (int w = 0; w < n; w++) begin
      #1;
      total++; if (bus.rc_out_valid !== 1'b0 || bus.rc_mem_addr !== 6'(w) || bus.rc_mem_we !== 1'b0) begin
        bad++; $display("FAIL %s_issue%0d: valid=%b addr=%0d we=%b want valid=0 addr=%0d we=0",
                        tag, w, bus.rc_out_valid, bus.rc_mem_addr, bus.rc_mem_we, w);
      end
      tick();
      exp = base + 32'(w);
      if (w == stall_word) begin
        bus.rc_out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          #1;
          total++; if (bus.rc_out_valid !== 1'b1 || bus.rc_data_out !== exp) begin
            bad++; $display("FAIL %s_stall%0d: valid=%b data=%h want valid=1 data=%h",
                            tag, s, bus.rc_out_valid, bus.rc_data_out, exp);
          end
          tick();
        end
        bus.rc_out_ready = 1'b1;
      end
      #1;
      total++; if (bus.rc_out_valid !== 1'b1 || bus.rc_data_out !== exp) begin
        bad++; $display("FAIL %s_word%0d: valid=%b data=%h want valid=1 data=%h",
                        tag, w, bus.rc_out_valid, bus.rc_data_out, exp);
      end
      tick();
    end
    #1;
    total++; if (rc_done !== 1'b1 || bus.rc_out_valid !== 1'b0 || rc_count !== 7'(n)) begin
      bad++; $display("FAIL %s_done: done=%b valid=%b count=%0d want done=1 valid=0 count=%0d",
                      tag, rc_done, bus.rc_out_valid, rc_count, n);
    end
    tick();
    #1;
    total++; if (rc_done !== 1'b0 || rc_busy !== 1'b0 || rc_count !== 7'(n)) begin
      bad++; $display("FAIL %s_idle: done=%b busy=%b count=%0d want 0 0 %0d", tag, rc_done, rc_busy, rc_count, n);
    end
  endtask

  task automatic test_collect4();
    rc_length = 6'd4;
    rc_cmd = CMD_COLLECT;
    tick();
    rc_cmd = CMD_NOP;
    for (int i = 0; i < 4; i++) begin
      fpu_valid = 1'b1;
      fpu_result = 32'h3F80_0000 + 32'(i);
      #1;
      total++; if (bus.rc_mem_we !== 1'b1 || bus.rc_mem_addr !== 6'(i) || bus.rc_mem_wdata !== fpu_result || rc_done !== 1'b0) begin
        bad++; $display("FAIL collect4_wr%0d: we=%b addr=%0d wdata=%h done=%b want we=1 addr=%0d wdata=%h done=0",
                        i, bus.rc_mem_we, bus.rc_mem_addr, bus.rc_mem_wdata, rc_done, i, fpu_result);
      end
      tick();
    end
    fpu_valid = 1'b0;
    #1;
    total++; if (rc_done !== 1'b1 || rc_count !== 7'd4) begin
      bad++; $display("FAIL collect4_done: done=%b count=%0d want done=1 count=4", rc_done, rc_count);
    end
    tick();
    #1;
    total++; if (rc_done !== 1'b0 || rc_busy !== 1'b0) begin
      bad++; $display("FAIL collect4_idle: done=%b busy=%b want 0 0", rc_done, rc_busy);
    end
  endtask

  task automatic test_drain();
    run_drain(4, 32'h3F80_0000, -1, 0, "drain");
  endtask

  task automatic test_drain_stall();
    run_drain(4, 32'h3F80_0000, 1, 5, "stall");
  endtask

  task automatic test_collect_sparse();
    rc_length = 6'd3;
    rc_cmd = CMD_COLLECT;
    tick();
    rc_cmd = CMD_NOP;
    for (int c = 0; c < 5; c++) begin
      fpu_valid = ((c % 2) == 0);
      fpu_result = 32'h0000_00A0 + 32'(c);
      #1;
      if (fpu_valid) begin
        total++; if (bus.rc_mem_we !== 1'b1 || bus.rc_mem_addr !== 6'(c / 2) || bus.rc_mem_wdata !== fpu_result) begin
          bad++; $display("FAIL sparse_wr%0d: we=%b addr=%0d wdata=%h want we=1 addr=%0d wdata=%h",
                          c, bus.rc_mem_we, bus.rc_mem_addr, bus.rc_mem_wdata, c / 2, fpu_result);
        end
      end else begin
        total++; if (bus.rc_mem_we !== 1'b0 || rc_done !== 1'b0) begin
          bad++; $display("FAIL sparse_gap%0d: we=%b done=%b want we=0 done=0", c, bus.rc_mem_we, rc_done);
        end
      end
      tick();
    end
    // Valid data during FINISH and IDLE must not be written.
    fpu_valid = 1'b1;
    fpu_result = 32'hDEAD_BEEF;
    #1;
    total++; if (rc_done !== 1'b1 || bus.rc_mem_we !== 1'b0 || rc_count !== 7'd3) begin
      bad++; $display("FAIL sparse_done: done=%b we=%b count=%0d want done=1 we=0 count=3", rc_done, bus.rc_mem_we, rc_count);
    end
    tick();
    #1;
    total++; if (bus.rc_mem_we !== 1'b0 || rc_busy !== 1'b0 || rc_count !== 7'd3) begin
      bad++; $display("FAIL sparse_idle: we=%b busy=%b count=%0d want 0 0 3", bus.rc_mem_we, rc_busy, rc_count);
    end
    fpu_valid = 1'b0;
    tick();
  endtask

  task automatic test_full();
    rc_length = 6'd0;
    rc_cmd = CMD_COLLECT;
    tick();
    rc_cmd = CMD_NOP;
    for (int i = 0; i < 64; i++) begin
      fpu_valid = 1'b1;
      fpu_result = 32'h1000_0000 + 32'(i);
      #1;
      total++; if (bus.rc_mem_we !== 1'b1 || bus.rc_mem_addr !== 6'(i) || rc_done !== 1'b0) begin
        bad++; $display("FAIL full_wr%0d: we=%b addr=%0d done=%b want we=1 addr=%0d done=0",
                        i, bus.rc_mem_we, bus.rc_mem_addr, rc_done, i);
      end
      tick();
    end
    fpu_valid = 1'b0;
    #1;
    total++; if (rc_done !== 1'b1 || rc_count !== 7'd64) begin
      bad++; $display("FAIL full_done: done=%b count=%0d want done=1 count=64", rc_done, rc_count);
    end
    tick();
    run_drain(64, 32'h1000_0000, -1, 0, "full");
  endtask

  task automatic test_abort_collect();
    rc_length = 6'd4;
    rc_cmd = CMD_COLLECT;
    tick();
    rc_cmd = CMD_NOP;
    for (int i = 0; i < 2; i++) begin
      fpu_valid = 1'b1;
      fpu_result = 32'h2000_0000 + 32'(i);
      #1;
      total++; if (bus.rc_mem_we !== 1'b1 || bus.rc_mem_addr !== 6'(i)) begin
        bad++; $display("FAIL abort_wr%0d: we=%b addr=%0d want we=1 addr=%0d", i, bus.rc_mem_we, bus.rc_mem_addr, i);
      end
      tick();
    end
    fpu_valid = 1'b0;
    rc_cmd = CMD_ABORT;
    #1;
    total++; if (rc_busy !== 1'b1 || rc_done !== 1'b0) begin
      bad++; $display("FAIL abort_cycle: busy=%b done=%b want busy=1 done=0", rc_busy, rc_done);
    end
    tick();
    rc_cmd = CMD_NOP;
    #1;
    total++; if (rc_busy !== 1'b0 || rc_done !== 1'b0 || rc_count !== 7'd2) begin
      bad++; $display("FAIL abort_idle: busy=%b done=%b count=%0d want 0 0 2", rc_busy, rc_done, rc_count);
    end
    tick();
    run_drain(2, 32'h2000_0000, 0, 2, "abort");
  endtask

  task automatic test_reset_mid_drain();
    rc_cmd = CMD_DRAIN;
    tick();
    // A new COLLECT while draining is ignored.
    rc_cmd = CMD_COLLECT;
    bus.rc_out_ready = 1'b0;
    tick();
    rc_cmd = CMD_NOP;
    #1;
    total++; if (bus.rc_out_valid !== 1'b1 || bus.rc_data_out !== 32'h2000_0000) begin
      bad++; $display("FAIL middrain_word: valid=%b data=%h want valid=1 data=20000000", bus.rc_out_valid, bus.rc_data_out);
    end
    #2;
    mc_reset = 1'b1;
    #1;
    total++; if (bus.rc_out_valid !== 1'b0 || bus.rc_data_out !== 32'h0 || rc_busy !== 1'b0) begin
      bad++; $display("FAIL middrain_rst_out: valid=%b data=%h busy=%b want 0 0 0", bus.rc_out_valid, bus.rc_data_out, rc_busy);
    end
    total++; if (rc_count !== 7'd0 || rc_done !== 1'b0 || bus.rc_mem_we !== 1'b0 || bus.rc_mem_addr !== 6'd0) begin
      bad++; $display("FAIL middrain_rst_stat: count=%0d done=%b we=%b addr=%0d want 0 0 0 0",
                      rc_count, rc_done, bus.rc_mem_we, bus.rc_mem_addr);
    end
    tick();
    mc_reset = 1'b0;
    bus.rc_out_ready = 1'b1;
    tick();
    #1;
    total++; if (rc_busy !== 1'b0 || rc_count !== 7'd0) begin
      bad++; $display("FAIL postrst: busy=%b count=%0d want 0 0", rc_busy, rc_count);
    end
  endtask

  initial begin
    test_reset();
    test_collect4();
    test_drain();
    test_drain_stall();
    test_collect_sparse();
    test_full();
    test_abort_collect();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/res_mem_ctrl.md
RES_MEM_CTRL -- requirements
Module: res_mem_ctrl

Interface
REQ-001 Parameter: DEPTH, 64, number of result-RAM entries (address width 6).
REQ-002 Parameter: DW, 32, result and data word width.
REQ-003 mc_clk  in  1  clock; all logic on the rising edge.
REQ-004 mc_reset  in  1  reset, asynchronous, active-high.
REQ-005 rc_cmd  in  3  command: 3'b100 COLLECT, 3'b010 DRAIN, 3'b001 ABORT; other codes are no-op.
REQ-006 rc_length  in  6  results to collect; 0 encodes 64; sampled only on an accepted COLLECT.
REQ-007 fpu_result  in  32  FPU result word.
REQ-008 fpu_valid  in  1  fpu_result valid this cycle; no backpressure to the FPU.
REQ-009 rc_mem_addr  out  6  result-RAM address.
REQ-010 rc_mem_we  out  1  result-RAM write enable.
REQ-011 rc_mem_wdata  out  32  result-RAM write data.
REQ-012 rc_mem_rdata  in  32  result-RAM read data, valid one cycle after the address (synchronous read).
REQ-013 rc_data_out  out  32  drained result word.
REQ-014 rc_out_valid  out  1  rc_data_out valid.
REQ-015 rc_out_ready  in  1  downstream accepts rc_data_out.
REQ-016 rc_done  out  1  one-cycle pulse at the end of COLLECT or DRAIN.
REQ-017 rc_count  out  7  results currently stored (0..64).
REQ-018 rc_busy  out  1  high in any state other than IDLE.

Function
REQ-019 States: IDLE, COLLECT, RD_ISSUE, RD_OUT, FINISH.
REQ-020 IDLE: rc_cmd=COLLECT -> COLLECT; clear rc_count and wr_ptr; latch target=(rc_length==0 ? 64 : rc_length).
REQ-021 IDLE: rc_cmd=DRAIN with rc_count>0 -> RD_ISSUE with rd_ptr=0; with rc_count==0 -> FINISH directly.
REQ-022 COLLECT: each cycle fpu_valid=1, combinationally drive rc_mem_we=1, rc_mem_addr=wr_ptr, rc_mem_wdata=fpu_result; at the edge increment wr_ptr and rc_count.
REQ-023 COLLECT: the edge that makes rc_count equal target -> FINISH; fpu_valid in FINISH/IDLE is ignored (no write).
REQ-024 RD_ISSUE: drive rc_mem_addr=rd_ptr, rc_mem_we=0; next cycle -> RD_OUT.
REQ-025 RD_OUT: register rc_mem_rdata into rc_data_out on entry; hold rc_out_valid=1 and rc_data_out stable until rc_out_ready=1.
REQ-026 RD_OUT handshake: rc_out_valid & rc_out_ready -> rd_ptr+1; if rd_ptr+1==rc_count -> FINISH, else -> RD_ISSUE; throughput one word per 2 cycles minimum.
REQ-027 FINISH: assert rc_done for exactly one cycle; next cycle -> IDLE.
REQ-028 DRAIN leaves rc_count unchanged; a second DRAIN replays the same data.
REQ-029 ABORT in any non-IDLE state -> IDLE next edge; no rc_done; rc_count keeps words already written; rc_out_valid drops.
REQ-030 Commands other than ABORT are ignored outside IDLE.
REQ-031 rc_mem_we=0 outside COLLECT; rc_mem_addr=0 when not otherwise driven.
REQ-032 wr_ptr/rd_ptr are 6 bits; rc_count is 7 bits so that 64 is representable; no wrap beyond target.

Reset
REQ-033 On mc_reset: state=IDLE, rc_count=0, wr_ptr=0, rd_ptr=0, target=64, rc_data_out=0, rc_out_valid=0, rc_done=0, rc_busy=0, rc_mem_we=0.
REQ-034 Reset mid-COLLECT or mid-DRAIN aborts immediately; RAM contents are not cleared, but rc_count=0 makes them unreadable.

Structure
REQ-035 Shared package res_mem_pkg holds the state enum, rc_cmd codes (CMD_COLLECT, CMD_DRAIN, CMD_ABORT), DEPTH and DW.
REQ-036 The result RAM is a separate sub-module res_ram (64x32, 1 write port, synchronous read), instantiated at top level next to res_mem_ctrl, not inside it.

Verification
REQ-037 COLLECT with rc_length=4; fpu_valid on 4 consecutive cycles with 0x3F800000..0x3F800003 -> 4 writes to addr 0..3, rc_done one cycle after the 4th write, rc_count=4.
REQ-038 COLLECT with rc_length=3; fpu_valid toggled every other cycle -> writes only on valid cycles, addresses 0,1,2, rc_done after the 3rd write.
REQ-039 DRAIN after REQ-037 with rc_out_ready=1 -> rc_data_out 0x3F800000..0x3F800003 in order, valid every 2nd cycle, rc_done pulse, rc_count still 4.
REQ-040 DRAIN with rc_out_ready held low 5 cycles on word 1 -> rc_data_out and rc_out_valid stable for those cycles; no word skipped or duplicated.
REQ-041 COLLECT rc_length=0 with 64 valids -> addresses 0..63 written, rc_count=64; DRAIN returns 64 words; DRAIN at rc_count=0 -> rc_done next cycle, no rc_out_valid.
REQ-042 ABORT after 2 of 4 collect writes -> IDLE, no rc_done, rc_count=2; mc_reset asserted mid-DRAIN -> all outputs at reset values asynchronously.
